// File: rtl/comparator_pkg.sv
// Shared ALU compare definitions: opcode encoding, default operand width
// and the predicate-select helper used by the comparator top level.
package comparator_pkg;

    localparam int unsigned CMP_LEN = 9;

    typedef enum logic [2:0] {
        CMP_GT = 3'b000,
        CMP_GE = 3'b001,
        CMP_LT = 3'b010,
        CMP_LE = 3'b011,
        CMP_EQ = 3'b100,
        CMP_NE = 3'b101
    } cmp_op_e;

    // Reserved encodings (110, 111) select a constant 0 predicate.
    function automatic logic cmp_select(
        input logic [2:0] op,
        input logic       gt,
        input logic       eq,
        input logic       lt
    );
        logic res;
        res = 1'b0;
        case (op)
            CMP_GT:  res = gt;
            CMP_GE:  res = gt | eq;
            CMP_LT:  res = lt;
            CMP_LE:  res = lt | eq;
            CMP_EQ:  res = eq;
            CMP_NE:  res = ~eq;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/comparator_cmp_core.sv
// Combinational magnitude/equality compare of two LEN-bit operands,
// two's-complement or unsigned depending on SIGNED.
module cmp_core
    import comparator_pkg::*;
#(
    parameter int unsigned LEN    = CMP_LEN,
    parameter bit          SIGNED = 1'b1
) (
    input  logic [LEN-1:0] in1_i,
    input  logic [LEN-1:0] in2_i,
    output logic           gt_o,
    output logic           eq_o,
    output logic           lt_o
);

    localparam logic FLIP = SIGNED;

    logic [LEN-1:0] a;
    logic [LEN-1:0] b;

    // Inverting the sign bit maps two's-complement ordering onto unsigned
    // ordering, so one unsigned compare serves both modes without overflow.
    always_comb begin
        a          = in1_i;
        b          = in2_i;
        a[LEN-1]   = in1_i[LEN-1] ^ FLIP;
        b[LEN-1]   = in2_i[LEN-1] ^ FLIP;
    end

    // Raw relational flags; exactly one is set for any operand pair.
    always_comb begin
        gt_o = (a > b);
        eq_o = (a == b);
        lt_o = (a < b);
    end

endmodule

// File: rtl/comparator.sv
// Registered two-operand comparator: raw gt/eq/lt flags plus one predicate
// chosen by op, all with one cycle of latency.
module comparator
    import comparator_pkg::*;
#(
    parameter int unsigned LEN    = CMP_LEN,
    parameter bit          SIGNED = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [LEN-1:0] in1,
    input  logic [LEN-1:0] in2,
    input  logic [2:0]     op,
    output logic           out,
    output logic           gt,
    output logic           eq,
    output logic           lt
);

    logic gt_c, eq_c, lt_c;
    logic out_d;
    logic out_q, gt_q, eq_q, lt_q;

    cmp_core #(
        .LEN    (LEN),
        .SIGNED (SIGNED)
    ) u_core (
        .in1_i (in1),
        .in2_i (in2),
        .gt_o  (gt_c),
        .eq_o  (eq_c),
        .lt_o  (lt_c)
    );

    // Select the requested predicate from the fresh flags.
    always_comb begin
        out_d = cmp_select(op, gt_c, eq_c, lt_c);
    end

    // Output registers; reset clears everything and discards the in-flight compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= 1'b0;
            gt_q  <= 1'b0;
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            gt_q  <= gt_c;
            eq_q  <= eq_c;
            lt_q  <= lt_c;
        end
    end

    assign out = out_q;
    assign gt  = gt_q;
    assign eq  = eq_q;
    assign lt  = lt_q;

endmodule

// File: tb/tb_comparator.sv
// Directed bench for comparator: a signed and an unsigned instance share
// stimulus; expected results are queued at drive time and popped after the edge.
module tb_comparator;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] in1, in2;
    logic [2:0] op;
    logic       out_s, gt_s, eq_s, lt_s;
    logic       out_u, gt_u, eq_u, lt_u;

    typedef struct packed {
        logic out;
        logic gt;
        logic eq;
        logic lt;
    } res_t;

    res_t exp_s_q[$];
    res_t exp_u_q[$];
    res_t last_s, last_u;
    bit   have_last = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    comparator #(.LEN(9), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .in1(in1), .in2(in2), .op(op),
        .out(out_s), .gt(gt_s), .eq(eq_s), .lt(lt_s)
    );

    comparator #(.LEN(9), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .in1(in1), .in2(in2), .op(op),
        .out(out_u), .gt(gt_u), .eq(eq_u), .lt(lt_u)
    );

    // Reference: convert to integers and compare arithmetically.
    function automatic res_t model(input logic r, input logic [8:0] a, input logic [8:0] b,
                                   input logic [2:0] o, input bit sgn);
        res_t e;
        int   ia, ib;
        e = '0;
        if (r) return e;
        ia = int'(a);
        ib = int'(b);
        if (sgn && a[8]) ia = ia - 512;
        if (sgn && b[8]) ib = ib - 512;
        e.gt = (ia > ib);
        e.eq = (ia == ib);
        e.lt = (ia < ib);
        case (o)
            3'd0:    e.out = (ia > ib);
            3'd1:    e.out = (ia >= ib);
            3'd2:    e.out = (ia < ib);
            3'd3:    e.out = (ia <= ib);
            3'd4:    e.out = (ia == ib);
            3'd5:    e.out = (ia != ib);
            default: e.out = 1'b0;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input res_t obs, input res_t expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed out/gt/eq/lt=%b required %b", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [8:0] a,
                        input logic [8:0] b, input logic [2:0] o);
        res_t es, eu, ps, pu;
        @(negedge clk);
        reset = r;
        in1   = a;
        in2   = b;
        op    = o;
        exp_s_q.push_back(model(r, a, b, o, 1'b1));
        exp_u_q.push_back(model(r, a, b, o, 1'b0));
        #1;
        // Registered outputs must not react before the clock edge.
        if (have_last) begin
            check({tag, "/hold_s"}, {out_s, gt_s, eq_s, lt_s}, last_s);
            check({tag, "/hold_u"}, {out_u, gt_u, eq_u, lt_u}, last_u);
        end
        @(posedge clk);
        #1;
        es = exp_s_q.pop_front();
        eu = exp_u_q.pop_front();
        ps = {out_s, gt_s, eq_s, lt_s};
        pu = {out_u, gt_u, eq_u, lt_u};
        check({tag, "/signed"}, ps, es);
        check({tag, "/unsigned"}, pu, eu);
        if (!r) begin
            check({tag, "/onehot_s"}, {3'b0, $onehot({gt_s, eq_s, lt_s})}, 4'b0001);
        end
        last_s    = es;
        last_u    = eu;
        have_last = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        in1   = '0;
        in2   = '0;
        op    = '0;

        step("rst0", 1'b1, 9'd5, 9'd3, 3'b000);
        step("rst1", 1'b1, 9'd5, 9'd3, 3'b000);
        step("rel_gt", 1'b0, 9'd5, 9'd3, 3'b000);

        step("neg100_gt", 1'b0, 9'h19C, 9'd88, 3'b000);
        step("neg100_lt", 1'b0, 9'h19C, 9'd88, 3'b010);

        step("trunc_gt", 1'b0, 9'd225, 9'h143, 3'b000);

        step("121_gt", 1'b0, 9'd121, 9'd231, 3'b000);
        step("121_ne", 1'b0, 9'd121, 9'd231, 3'b101);
        step("121_le", 1'b0, 9'd121, 9'd231, 3'b011);

        step("min_ge", 1'b0, 9'h100, 9'h100, 3'b001);
        step("min_eq", 1'b0, 9'h100, 9'h100, 3'b100);
        step("min_gt", 1'b0, 9'h100, 9'h100, 3'b000);
        step("min_vs_max", 1'b0, 9'h100, 9'h0FF, 3'b010);
        step("rsv110", 1'b0, 9'h100, 9'h100, 3'b110);
        step("rsv111", 1'b0, 9'h0FF, 9'h100, 3'b111);
        step("ones_ge", 1'b0, 9'h1FF, 9'h000, 3'b001);
        step("ones_le", 1'b0, 9'h1FF, 9'h1FE, 3'b011);

        step("b2b0", 1'b0, 9'd17, 9'd40, 3'b000);
        step("b2b1", 1'b0, 9'h1F0, 9'd2, 3'b010);
        step("b2b2_rst", 1'b1, 9'd99, 9'd99, 3'b100);
        step("b2b3", 1'b0, 9'd300, 9'd7, 3'b001);

        for (int i = 0; i < 40; i++) begin
            step("rand", 1'b0, 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                 3'($urandom_range(0, 7)));
        end
        step("rand_eq", 1'b0, 9'd256, 9'd256, 3'b101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
